pwm_multi: RTL

Parametrised N-channel PWM generator with a shared prescaler and period counter, per-channel double-buffered duty registers, and a per-channel hardware fade (ramp-to-target) mode. It replaces the fixed two-instance, constant-duty PWM pair that drives the RGB LED. A small write port lets the SoC GPIO/Wishbone glue load new duties or fade targets at run time. Every duty change is applied at a period boundary, so outputs never glitch mid-period.

---
 rtl/pwm_multi_pkg.sv | 25 ++
 rtl/pwm_channel.sv | 60 ++++++
 rtl/pwm_multi.sv | 64 ++++++
 3 files changed

// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: width helpers, prescaler derivation and write-kind encoding
package pwm_multi_pkg;

    typedef enum logic {WR_DIRECT = 1'b0, WR_FADE = 1'b1} wr_kind_e;

    function automatic int clog2(input longint v);
        int     r = 0;
        longint x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input longint n);
        return clog2(n) < 1 ? 1 : clog2(n);
    endfunction

    function automatic int presc_of(input longint clk_hz, input longint pwm_hz, input int width);
        longint p = clk_hz / (pwm_hz * (longint'(1) << width));
        return p < 1 ? 1 : int'(p);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with double-buffered duty and ramp-to-target fade
module pwm_channel
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FADE_DIV = 256
) (
    input  logic             io_clk,
    input  logic             io_resetn,
    input  logic [WIDTH-1:0] cnt,
    input  logic             wrap,
    input  logic             wr,
    input  logic             wr_fade,
    input  logic [WIDTH-1:0] wr_data,
    output logic             pwm_out,
    output logic             fading
);

    localparam int DW = cnt_w(FADE_DIV);

    logic [WIDTH-1:0] shadow, target, act;
    logic             mode;
    logic [DW-1:0]    div;
    logic             step_now;

    assign step_now = div == DW'(FADE_DIV - 1);

    always_ff @(posedge io_clk or negedge io_resetn) begin
        if (!io_resetn) begin
            shadow  <= '0;
            target  <= '0;
            act     <= '0;
            mode    <= 1'b0;
            div     <= '0;
            pwm_out <= 1'b0;
            fading  <= 1'b0;
        end else begin
            if (wrap && !mode)
                act <= shadow;
            if (wrap && mode) begin
                div <= step_now ? '0 : div + 1'b1;
                if (step_now && act != target)
                    act <= act < target ? act + 1'b1 : act - 1'b1;
            end
            // writes come last so a fade write on a wrap edge still restarts the divider
            if (wr && wr_fade == WR_FADE) begin
                target <= wr_data;
                mode   <= 1'b1;
                div    <= '0;
            end
            if (wr && wr_fade == WR_DIRECT) begin
                shadow <= wr_data;
                mode   <= 1'b0;
            end
            pwm_out <= cnt < act;
            fading  <= mode && act != target;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM with shared prescaler/period counter and per-channel fade
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int CLK_FREQ = 27_000_000,
    parameter int PWM_FREQ = 50_000,
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int FADE_DIV = 256
) (
    input  logic                       io_clk,
    input  logic                       io_resetn,
    input  logic                       wr_en,
    input  logic [cnt_w(CHANNELS)-1:0] wr_ch,
    input  logic                       wr_fade,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [CHANNELS-1:0]        pwm_out,
    output logic [CHANNELS-1:0]        fading,
    output logic                       period_start
);

    localparam int PRESC = presc_of(CLK_FREQ, PWM_FREQ, WIDTH);
    localparam int PW    = cnt_w(PRESC);

    logic [PW-1:0]    psc;
    logic [WIDTH-1:0] cnt;
    logic             tick, wrap, wrap_q;

    assign tick = psc == PW'(PRESC - 1);
    assign wrap = tick && &cnt;

    // period_start trails the wrap by two edges so it lines up with pwm_out showing cnt=0
    always_ff @(posedge io_clk or negedge io_resetn) begin
        if (!io_resetn) begin
            psc          <= '0;
            cnt          <= '0;
            wrap_q       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            psc          <= tick ? '0 : psc + 1'b1;
            cnt          <= tick ? cnt + 1'b1 : cnt;
            wrap_q       <= wrap;
            period_start <= wrap_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH   (WIDTH),
            .FADE_DIV(FADE_DIV)
        ) u_ch (
            .io_clk   (io_clk),
            .io_resetn(io_resetn),
            .cnt      (cnt),
            .wrap     (wrap),
            .wr       (wr_en && 32'(wr_ch) == i),
            .wr_fade  (wr_fade),
            .wr_data  (wr_data),
            .pwm_out  (pwm_out[i]),
            .fading   (fading[i])
        );
    end

endmodule
